memory_controller: RTL and testbench
====================================

Name: memory_controller

Overview:
- Single arbiter between the instruction-fetch unit and the load/store buffer (LSB) for the one byte-wide external RAM port.
- Serialises word, half and byte accesses into little-endian byte beats.
- Sign- or zero-extends load results.
- Returns one-cycle completion pulses: mem_valid/mem_res to the LSB, if_valid/if_data to fetch.

Parameters:
- IO_PREFIX, 2'b11: value of addr[17:16] that marks memory-mapped I/O; writes there stall while io_buffer_full.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; low freezes the block
- wrong_commit  in  1  mispredict flush from ROB
- if_enable  in  1  fetch request
- if_addr  in  32  fetch word address
- if_valid  out  1  fetch done pulse
- if_data  out  32  fetched instruction
- load_store_enable  in  1  LSB request
- load_store_addr  in  32  LSB byte address
- load_store_data  in  32  store data; low bytes used
- load_or_store  in  1  1 = load, 0 = store
- load_store_op  in  7  const_def opcode: LB/LH/LW/LBU/LHU/SB/SH/SW
- mem_valid  out  1  LSB done pulse
- mem_res  out  32  extended load result; 0 for stores
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART buffer full

Behaviour:
- Reset (async on rst high), state IDLE: if_valid=0, if_data=0, mem_valid=0, mem_res=0, mem_dout=0, mem_a=0, mem_wr=0, byte counter=0.
- rdy=0: all registers hold; mem_wr is gated combinationally by rdy, so no write occurs while rdy is low.
- Access width N from op:
  - LB/LBU/SB: N=1
  - LH/LHU/SH: N=2
  - LW/SW: N=4
  - Fetch: always N=4
- States: IDLE, IF_READ, LS_READ, LS_WRITE. A 2-bit byte counter k and a 32-bit assembly buffer are kept.
- IDLE arbitration. A request is accepted at cycle T only if no done pulse is high in T (one-cycle turnaround, because requesters drop enable on the edge after the pulse).
  - load_store_enable has priority over if_enable.
  - Accepted request goes to LS_READ, LS_WRITE or IF_READ.
  - Address, op and data are latched at acceptance; later changes on the inputs are ignored.
- Reads (IF_READ, LS_READ):
  - Cycles T+1..T+N: mem_a = addr+k, mem_wr=0.
  - RAM returns the byte one cycle after the address; byte k is captured at the end of cycle T+k+2.
  - Done pulse is high for exactly cycle T+N+2; the block is in IDLE during that cycle.
  - Result: byte 0 in [7:0], ascending.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Writes (LS_WRITE):
  - Cycles T+1..T+N: mem_a = addr+k, mem_dout = data byte k, mem_wr=1.
  - mem_valid is high for exactly cycle T+N+1; mem_res=0.
- I/O stall: if addr[17:16]==IO_PREFIX and io_buffer_full=1 at a write beat, that beat is not issued (mem_wr=0) and retries every cycle until io_buffer_full=0. Total write latency stretches by the stall length.
- Address arithmetic is 32-bit modulo; no alignment check; an access may cross any boundary.
- wrong_commit (with rdy=1), next edge:
  - IF_READ: aborted, go IDLE, no if_valid.
  - LS_READ: aborted, go IDLE, no mem_valid.
  - LS_WRITE: committed store runs to completion, but mem_valid is suppressed.
  - IDLE: no request is accepted that cycle.
- Both done outputs are registered and never high together; each pulse lasts one cycle.
- Reset mid-access: immediate return to IDLE, mem_wr=0, no pulse.

Test Plan:
- RAM[0x100..0x103]=13 00 00 00, if_addr=0x100 accepted at cycle 0 -> mem_a=0x100..0x103 in cycles 1-4, mem_wr=0, if_valid only in cycle 6, if_data=0x00000013.
- RAM[0x200]=0xF0, LB to 0x200 -> mem_res=0xFFFFFFF0, mem_valid at cycle 3. LBU to the same address -> 0x000000F0.
- SH of data 0x1234ABCD to 0x2FF -> mem_wr=1 at cycles 1-2 with (0x2FF, CD), (0x300, AB); mem_valid at cycle 3 with mem_res=0.
- if_enable and load_store_enable both rise in the same IDLE cycle -> LSB access is served first. Fetch is accepted only in the cycle after mem_valid, with if_valid 6 cycles later.
- SB of 0x41 to 0x30000 with io_buffer_full high for 5 cycles -> mem_wr=0 throughout the stall, one write in the cycle after io_buffer_full falls, mem_valid the following cycle.
- wrong_commit during cycle 2 of a fetch -> no if_valid, IDLE next cycle. wrong_commit during SW beat 1 -> all 4 bytes still written, mem_valid stays 0. rdy low for 3 cycles mid-LW -> completion delayed by exactly 3 cycles with identical data.

Source files
------------

// File: rtl/memory_controller_if.sv
// Request, completion and byte-wide RAM signals shared between the memory controller and
// its requesters (fetch, LSB, UART and RAM).
interface memory_controller_if;
  logic        rdy;
  logic        wrong_commit;
  logic        if_enable;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_data;
  logic        load_store_enable;
  logic [31:0] load_store_addr;
  logic [31:0] load_store_data;
  logic        load_or_store;
  logic [6:0]  load_store_op;
  logic        mem_valid;
  logic [31:0] mem_res;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  rdy, wrong_commit, if_enable, if_addr, load_store_enable, load_store_addr,
           load_store_data, load_or_store, load_store_op, mem_din, io_buffer_full,
    output if_valid, if_data, mem_valid, mem_res, mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy, wrong_commit, if_enable, if_addr, load_store_enable, load_store_addr,
           load_store_data, load_or_store, load_store_op, mem_din, io_buffer_full,
    input  if_valid, if_data, mem_valid, mem_res, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/memory_controller.sv
// Arbitrates fetch and load/store traffic onto one byte-wide RAM port, serialising accesses
// into little-endian beats and returning registered one-cycle completion pulses.
module memory_controller #(
  parameter logic [1:0] IO_PREFIX = 2'b11
) (
  input  logic                clk,
  input  logic                rst,
  memory_controller_if.slave  bus
);

  localparam logic [6:0] OpLb  = 7'd1;
  localparam logic [6:0] OpLh  = 7'd2;
  localparam logic [6:0] OpLw  = 7'd3;
  localparam logic [6:0] OpLbu = 7'd4;
  localparam logic [6:0] OpLhu = 7'd5;
  localparam logic [6:0] OpSb  = 7'd6;
  localparam logic [6:0] OpSh  = 7'd7;
  localparam logic [6:0] OpSw  = 7'd8;

  typedef enum logic [1:0] {StIdle, StIfRead, StLsRead, StLsWrite} state_e;

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic        tail_q, tail_d;
  logic        kill_q, kill_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [6:0]  op_q, op_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] a_last_q, a_last_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_data_q, if_data_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_res_q, mem_res_d;

  logic [31:0] beat_a, act_a, word;
  logic [1:0]  last_k, cap_k;
  logic [7:0]  act_dout;
  logic        act_wr, stall;

  function automatic logic [1:0] last_beat(input logic [6:0] op);
    case (op)
      OpLb, OpLbu, OpSb: last_beat = 2'd0;
      OpLh, OpLhu, OpSh: last_beat = 2'd1;
      default:           last_beat = 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [6:0] op, input logic [31:0] w);
    case (op)
      OpLb:    extend = {{24{w[7]}}, w[7:0]};
      OpLh:    extend = {{16{w[15]}}, w[15:0]};
      OpLbu:   extend = {24'd0, w[7:0]};
      OpLhu:   extend = {16'd0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  assign last_k = last_beat(op_q);
  // Byte on mem_din belongs to the beat issued one cycle earlier; wraps to 3 in the tail.
  assign cap_k  = k_q - 2'd1;
  assign beat_a = addr_q + {30'd0, k_q};
  assign stall  = (beat_a[17:16] == IO_PREFIX) && bus.io_buffer_full;

  always_comb begin
    word = buf_q;
    word[{cap_k, 3'b000} +: 8] = bus.mem_din;
  end

  always_comb begin
    act_a    = '0;
    act_wr   = 1'b0;
    act_dout = '0;
    unique case (state_q)
      StIfRead, StLsRead: begin
        if (!tail_q) act_a = beat_a;
      end
      StLsWrite: begin
        act_a    = beat_a;
        act_dout = data_q[{k_q, 3'b000} +: 8];
        act_wr   = !stall;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    tail_d      = tail_q;
    kill_d      = kill_q;
    addr_d      = addr_q;
    data_d      = data_q;
    op_d        = op_q;
    buf_d       = buf_q;
    a_last_d    = a_last_q;
    if_valid_d  = if_valid_q;
    if_data_d   = if_data_q;
    mem_valid_d = mem_valid_q;
    mem_res_d   = mem_res_q;

    if (bus.rdy) begin
      if_valid_d  = 1'b0;
      mem_valid_d = 1'b0;
      a_last_d    = act_a;
      unique case (state_q)
        StIdle: begin
          if (!bus.wrong_commit && !if_valid_q && !mem_valid_q &&
              (bus.load_store_enable || bus.if_enable)) begin
            k_d    = 2'd0;
            tail_d = 1'b0;
            kill_d = 1'b0;
            buf_d  = '0;
            if (bus.load_store_enable) begin
              addr_d  = bus.load_store_addr;
              data_d  = bus.load_store_data;
              op_d    = bus.load_store_op;
              state_d = bus.load_or_store ? StLsRead : StLsWrite;
            end else begin
              addr_d  = bus.if_addr;
              op_d    = OpLw;
              state_d = StIfRead;
            end
          end
        end
        StIfRead, StLsRead: begin
          if (bus.wrong_commit) begin
            state_d = StIdle;
            k_d     = 2'd0;
            tail_d  = 1'b0;
          end else if (!tail_q) begin
            if (k_q != 2'd0) buf_d = word;
            k_d    = k_q + 2'd1;
            tail_d = (k_q == last_k);
          end else begin
            state_d = StIdle;
            k_d     = 2'd0;
            tail_d  = 1'b0;
            if (state_q == StIfRead) begin
              if_valid_d = 1'b1;
              if_data_d  = word;
            end else begin
              mem_valid_d = 1'b1;
              mem_res_d   = extend(op_q, word);
            end
          end
        end
        StLsWrite: begin
          // A committed store must land even if flushed; only its completion is hidden.
          if (bus.wrong_commit) kill_d = 1'b1;
          if (!stall) begin
            if (k_q == last_k) begin
              state_d     = StIdle;
              k_d         = 2'd0;
              mem_valid_d = !(kill_q || bus.wrong_commit);
              mem_res_d   = '0;
            end else begin
              k_d = k_q + 2'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= 2'd0;
      tail_q      <= 1'b0;
      kill_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      op_q        <= '0;
      buf_q       <= '0;
      a_last_q    <= '0;
      if_valid_q  <= 1'b0;
      if_data_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_res_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      tail_q      <= tail_d;
      kill_q      <= kill_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      op_q        <= op_d;
      buf_q       <= buf_d;
      a_last_q    <= a_last_d;
      if_valid_q  <= if_valid_d;
      if_data_q   <= if_data_d;
      mem_valid_q <= mem_valid_d;
      mem_res_q   <= mem_res_d;
    end
  end

  // While frozen, replay the last issued address so the RAM keeps returning the byte that
  // the first active cycle afterwards expects to capture.
  assign bus.mem_a     = bus.rdy ? act_a : a_last_q;
  assign bus.mem_wr    = act_wr & bus.rdy;
  assign bus.mem_dout  = act_dout;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_res   = mem_res_q;

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: byte-wide RAM model plus per-scenario tasks that check
// beats and completions against result and write scoreboards.
module tb_memory_controller;

  localparam logic [6:0] OpLb  = 7'd1;
  localparam logic [6:0] OpLh  = 7'd2;
  localparam logic [6:0] OpLw  = 7'd3;
  localparam logic [6:0] OpLbu = 7'd4;
  localparam logic [6:0] OpLhu = 7'd5;
  localparam logic [6:0] OpSb  = 7'd6;
  localparam logic [6:0] OpSh  = 7'd7;
  localparam logic [6:0] OpSw  = 7'd8;

  logic clk;
  logic rst;
  memory_controller_if bus ();

  memory_controller #(.IO_PREFIX(2'b11)) dut (.clk(clk), .rst(rst), .bus(bus));

  bit   [7:0]  ram [0:262143];
  logic        pre_we;
  logic [17:0] pre_addr;
  logic [7:0]  pre_data;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a[17:0]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;
  logic [31:0] sb_q [$];
  logic [39:0] wr_q [$];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.rdy = 1'b1; bus.wrong_commit = 1'b0; bus.if_enable = 1'b0; bus.if_addr = '0;
    bus.load_store_enable = 1'b0; bus.load_store_addr = '0; bus.load_store_data = '0;
    bus.load_or_store = 1'b0; bus.load_store_op = '0; bus.io_buffer_full = 1'b0;
  endtask

  task automatic preload(input logic [17:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic ls_req(input logic [6:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic is_load);
    bus.load_store_enable = 1'b1; bus.load_store_op = op; bus.load_store_addr = a;
    bus.load_store_data = d; bus.load_or_store = is_load;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) step();
    #1;
    tests_run++;
    if ({bus.if_valid, bus.mem_valid, bus.mem_wr} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 000", {bus.if_valid, bus.mem_valid, bus.mem_wr});
    end
    tests_run++;
    if (bus.if_data !== 32'd0 || bus.mem_res !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got if_data=%h mem_res=%h want 0", bus.if_data, bus.mem_res);
    end
    tests_run++;
    if (bus.mem_a !== 32'd0 || bus.mem_dout !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_bus: got mem_a=%h mem_dout=%h want 0", bus.mem_a, bus.mem_dout);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    int pulses = 0;
    logic [31:0] exp;
    preload(18'h100, 8'h13); preload(18'h101, 8'h00);
    preload(18'h102, 8'h00); preload(18'h103, 8'h00);
    bus.if_enable = 1'b1; bus.if_addr = 32'h100;
    sb_q.push_back(32'h0000_0013);
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) begin bus.if_enable = 1'b0; bus.if_addr = 32'hDEAD_0000; end
      #1;
      if (c <= 4) begin
        tests_run++;
        if (bus.mem_a !== 32'h100 + 32'(c - 1) || bus.mem_wr !== 1'b0) begin
          tests_failed++;
          $display("FAIL fetch_beat%0d: got a=%h wr=%b want a=%h wr=0", c, bus.mem_a,
                   bus.mem_wr, 32'h100 + 32'(c - 1));
        end
      end
      if (bus.if_valid === 1'b1 || bus.mem_valid === 1'b1) begin
        pulses++;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hBAD0_BAD0;
        tests_run++;
        if (c != 6 || bus.if_valid !== 1'b1 || bus.if_data !== exp) begin
          tests_failed++;
          $display("FAIL fetch_done: got cycle %0d data %h want cycle 6 data %h", c,
                   bus.if_data, exp);
        end
      end
    end
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL fetch_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_load_ext();
    logic [6:0]  ops  [4] = '{OpLb, OpLbu, OpLh, OpLhu};
    logic [31:0] exps [4] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0, 32'h0000_80F0};
    int          lat  [4] = '{3, 3, 4, 4};
    logic [31:0] exp;
    int pulses;
    preload(18'h200, 8'hF0); preload(18'h201, 8'h80);
    for (int i = 0; i < 4; i++) begin
      pulses = 0;
      ls_req(ops[i], 32'h200, 32'h0, 1'b1);
      sb_q.push_back(exps[i]);
      for (int c = 1; c <= 7; c++) begin
        step();
        if (c == 1) begin bus.load_store_enable = 1'b0; bus.load_store_addr = 32'h0; end
        #1;
        if (bus.mem_valid === 1'b1 || bus.if_valid === 1'b1) begin
          pulses++;
          exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hBAD0_BAD0;
          tests_run++;
          if (c != lat[i] || bus.mem_valid !== 1'b1 || bus.mem_res !== exp) begin
            tests_failed++;
            $display("FAIL load_ext%0d: got cycle %0d res %h want cycle %0d res %h", i, c,
                     bus.mem_res, lat[i], exp);
          end
        end
      end
      tests_run++;
      if (pulses != 1) begin
        tests_failed++;
        $display("FAIL load_ext%0d_pulses: got %0d want 1", i, pulses);
      end
    end
  endtask

  task automatic test_store_half();
    logic [39:0] ew;
    logic [31:0] exp;
    int wrs = 0;
    int pulses = 0;
    ls_req(OpSh, 32'h2FF, 32'h1234_ABCD, 1'b0);
    wr_q.push_back({32'h2FF, 8'hCD});
    wr_q.push_back({32'h300, 8'hAB});
    sb_q.push_back(32'h0);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) bus.load_store_enable = 1'b0;
      #1;
      if (bus.mem_wr === 1'b1) begin
        wrs++;
        ew = (wr_q.size() != 0) ? wr_q.pop_front() : 40'hBAD;
        tests_run++;
        if (c > 2 || {bus.mem_a, bus.mem_dout} !== ew) begin
          tests_failed++;
          $display("FAIL sh_write: got cycle %0d %h/%h want %h/%h", c, bus.mem_a,
                   bus.mem_dout, ew[39:8], ew[7:0]);
        end
      end
      if (bus.mem_valid === 1'b1) begin
        pulses++;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hBAD0_BAD0;
        tests_run++;
        if (c != 3 || bus.mem_res !== exp) begin
          tests_failed++;
          $display("FAIL sh_done: got cycle %0d res %h want cycle 3 res %h", c, bus.mem_res,
                   exp);
        end
      end
    end
    tests_run++;
    if (wrs != 2 || pulses != 1) begin
      tests_failed++;
      $display("FAIL sh_counts: got %0d writes %0d pulses want 2 and 1", wrs, pulses);
    end
    // Read back across the 0x2FF/0x300 boundary.
    ls_req(OpLhu, 32'h2FF, 32'h0, 1'b1);
    sb_q.push_back(32'h0000_ABCD);
    pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) bus.load_store_enable = 1'b0;
      #1;
      if (bus.mem_valid === 1'b1) begin
        pulses++;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hBAD0_BAD0;
        tests_run++;
        if (c != 4 || bus.mem_res !== exp) begin
          tests_failed++;
          $display("FAIL sh_readback: got cycle %0d res %h want cycle 4 res %h", c,
                   bus.mem_res, exp);
        end
      end
    end
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL sh_readback_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_priority();
    int ls_cyc = -1;
    int if_cyc = -1;
    logic [31:0] exp_ls = 32'hFFFF_FFF0;
    logic [31:0] exp_if = 32'h0000_0013;
    ls_req(OpLb, 32'h200, 32'h0, 1'b1);
    bus.if_enable = 1'b1; bus.if_addr = 32'h100;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 4)  bus.load_store_enable = 1'b0;
      if (c == 11) bus.if_enable = 1'b0;
      #1;
      if (c == 5) begin
        tests_run++;
        if (bus.mem_a !== 32'h100) begin
          tests_failed++;
          $display("FAIL prio_fetch_start: got mem_a %h want 00000100", bus.mem_a);
        end
      end
      if (bus.mem_valid === 1'b1) begin
        ls_cyc = c;
        tests_run++;
        if (bus.mem_res !== exp_ls || bus.if_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL prio_ls_data: got %h if_valid %b want %h", bus.mem_res, bus.if_valid,
                   exp_ls);
        end
      end
      if (bus.if_valid === 1'b1) begin
        if_cyc = c;
        tests_run++;
        if (bus.if_data !== exp_if) begin
          tests_failed++;
          $display("FAIL prio_if_data: got %h want %h", bus.if_data, exp_if);
        end
      end
    end
    tests_run++;
    if (ls_cyc != 3 || if_cyc != 10) begin
      tests_failed++;
      $display("FAIL prio_order: got ls %0d if %0d want ls 3 if 10", ls_cyc, if_cyc);
    end
  endtask

  task automatic test_io_stall();
    logic [39:0] ew;
    int stalled_wr = 0;
    int wr_cyc = -1;
    int done_cyc = -1;
    ls_req(OpSb, 32'h0003_0000, 32'h0000_0041, 1'b0);
    wr_q.push_back({32'h0003_0000, 8'h41});
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) begin bus.load_store_enable = 1'b0; bus.io_buffer_full = 1'b1; end
      if (c == 6) bus.io_buffer_full = 1'b0;
      #1;
      if (bus.mem_wr === 1'b1) begin
        if (c <= 5) stalled_wr++;
        wr_cyc = c;
        ew = (wr_q.size() != 0) ? wr_q.pop_front() : 40'hBAD;
        tests_run++;
        if ({bus.mem_a, bus.mem_dout} !== ew) begin
          tests_failed++;
          $display("FAIL io_write: got %h/%h want %h/%h", bus.mem_a, bus.mem_dout, ew[39:8],
                   ew[7:0]);
        end
      end
      if (bus.mem_valid === 1'b1) done_cyc = c;
    end
    tests_run++;
    if (stalled_wr != 0 || wr_cyc != 6 || done_cyc != 7) begin
      tests_failed++;
      $display("FAIL io_timing: got stalled %0d write %0d done %0d want 0 6 7", stalled_wr,
               wr_cyc, done_cyc);
    end
  endtask

  task automatic test_wrong_commit();
    int if_pulses = 0;
    int ls_cyc = -1;
    int wrs = 0;
    int pulses = 0;
    logic [39:0] ew;
    // Fetch flushed in its second cycle; controller must accept an LB the next cycle.
    bus.if_enable = 1'b1; bus.if_addr = 32'h100;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) bus.if_enable = 1'b0;
      bus.wrong_commit = (c == 2);
      if (c == 3) ls_req(OpLb, 32'h200, 32'h0, 1'b1);
      if (c == 4) bus.load_store_enable = 1'b0;
      #1;
      if (c == 3) begin
        tests_run++;
        if (bus.mem_a !== 32'h0) begin
          tests_failed++;
          $display("FAIL wc_fetch_idle: got mem_a %h want 00000000", bus.mem_a);
        end
      end
      if (bus.if_valid === 1'b1) if_pulses++;
      if (bus.mem_valid === 1'b1) ls_cyc = c;
    end
    tests_run++;
    if (if_pulses != 0 || ls_cyc != 6) begin
      tests_failed++;
      $display("FAIL wc_fetch: got if pulses %0d ls done %0d want 0 and 6", if_pulses, ls_cyc);
    end
    // Flushed SW still writes all four bytes, silently.
    ls_req(OpSw, 32'h400, 32'hDEAD_BEEF, 1'b0);
    wr_q.push_back({32'h400, 8'hEF}); wr_q.push_back({32'h401, 8'hBE});
    wr_q.push_back({32'h402, 8'hAD}); wr_q.push_back({32'h403, 8'hDE});
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) bus.load_store_enable = 1'b0;
      bus.wrong_commit = (c == 1);
      #1;
      if (bus.mem_wr === 1'b1) begin
        wrs++;
        ew = (wr_q.size() != 0) ? wr_q.pop_front() : 40'hBAD;
        tests_run++;
        if ({bus.mem_a, bus.mem_dout} !== ew) begin
          tests_failed++;
          $display("FAIL wc_sw_write: got %h/%h want %h/%h", bus.mem_a, bus.mem_dout,
                   ew[39:8], ew[7:0]);
        end
      end
      if (bus.mem_valid === 1'b1) pulses++;
    end
    tests_run++;
    if (wrs != 4 || pulses != 0) begin
      tests_failed++;
      $display("FAIL wc_sw_counts: got %0d writes %0d pulses want 4 and 0", wrs, pulses);
    end
    // Flush in IDLE blocks acceptance for that cycle only.
    ls_cyc = -1;
    ls_req(OpLb, 32'h200, 32'h0, 1'b1);
    bus.wrong_commit = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      bus.wrong_commit = 1'b0;
      if (c == 2) bus.load_store_enable = 1'b0;
      #1;
      if (bus.mem_valid === 1'b1) ls_cyc = c;
    end
    tests_run++;
    if (ls_cyc != 4) begin
      tests_failed++;
      $display("FAIL wc_idle: got done cycle %0d want 4", ls_cyc);
    end
  endtask

  task automatic test_rdy_stall();
    int pulses = 0;
    int wrs = 0;
    logic [31:0] exp;
    ls_req(OpLw, 32'h400, 32'h0, 1'b1);
    sb_q.push_back(32'hDEAD_BEEF);
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) bus.load_store_enable = 1'b0;
      bus.rdy = !(c >= 3 && c <= 5);
      #1;
      if (bus.mem_wr === 1'b1) wrs++;
      if (bus.mem_valid === 1'b1) begin
        pulses++;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hBAD0_BAD0;
        tests_run++;
        if (c != 9 || bus.mem_res !== exp) begin
          tests_failed++;
          $display("FAIL rdy_done: got cycle %0d res %h want cycle 9 res %h", c, bus.mem_res,
                   exp);
        end
      end
    end
    tests_run++;
    if (pulses != 1 || wrs != 0) begin
      tests_failed++;
      $display("FAIL rdy_counts: got %0d pulses %0d writes want 1 and 0", pulses, wrs);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int wrs = 0;
    ls_req(OpSw, 32'h500, 32'h1122_3344, 1'b0);
    step();
    bus.load_store_enable = 1'b0;
    step();
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.mem_wr !== 1'b0 || bus.mem_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: got wr %b valid %b want 0 0", bus.mem_wr, bus.mem_valid);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      #1;
      if (bus.mem_wr === 1'b1) wrs++;
      if (bus.mem_valid === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 0 || wrs != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_after: got %0d pulses %0d writes want 0 0", pulses, wrs);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset();
    test_fetch();
    test_load_ext();
    test_store_half();
    test_priority();
    test_io_stall();
    test_wrong_commit();
    test_rdy_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
